// File: rtl/wb_spi_bridge_if.sv
// Wishbone slave-side bus bundle between the management SoC and the SPI bridge.
// Signal names keep the slave-perspective _i/_o suffixes used on the SoC bus.
interface wb_spi_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_spi_bridge.sv
// Wishbone-controlled SPI mode-0 master for rapcore: firmware writes a byte, the
// block shifts it out MSB first and captures the CIPO reply for readback.
module wb_spi_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  DIV_RESET = 8'd3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_spi_bridge_if.slave  wb,
  output logic            sck_o,
  output logic            cs_o,
  output logic            copi_o,
  input  logic            cipo_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH
  } state_e;

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_RX     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sck_q, sck_d;
  logic        copi_q, copi_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  div_q, div_d;
  logic        cs_assert_q, cs_assert_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        hit;
  logic        busy;
  logic        start;
  logic [1:0]  reg_sel;
  logic        unused_bits;

  // The !ack term makes a held strobe see one ack per access, not one per cycle.
  assign hit     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q
                 & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = wb.wbs_adr_i[3:2];
  assign busy    = (state_q != S_IDLE);

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign sck_o        = sck_q;
  assign copi_o       = copi_q;
  assign cs_o         = ~cs_assert_q;

  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:9]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    copi_d      = copi_q;
    rxdata_d    = rxdata_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    div_d       = div_q;
    cs_assert_d = cs_assert_q;
    ack_d       = hit;
    dat_d       = '0;
    start       = 1'b0;

    if (hit && !wb.wbs_we_i) begin
      unique case (reg_sel)
        REG_TX:     dat_d = '0;
        REG_RX: begin
          dat_d      = {24'd0, rxdata_q};
          rx_valid_d = 1'b0;
        end
        REG_STATUS: dat_d = {29'd0, overrun_q, rx_valid_q, busy};
        REG_CTRL:   dat_d = {23'd0, cs_assert_q, div_q};
      endcase
    end

    if (hit && wb.wbs_we_i) begin
      unique case (reg_sel)
        REG_TX: begin
          if (wb.wbs_sel_i[0]) begin
            if (busy) overrun_d = 1'b1;
            else      start     = 1'b1;
          end
        end
        REG_RX: ;
        REG_STATUS: begin
          if (wb.wbs_sel_i[0] && wb.wbs_dat_i[2]) overrun_d = 1'b0;
        end
        REG_CTRL: begin
          // Rate and chip select stay frozen while a byte is on the wire.
          if (!busy) begin
            if (wb.wbs_sel_i[0]) div_d       = wb.wbs_dat_i[7:0];
            if (wb.wbs_sel_i[1]) cs_assert_d = wb.wbs_dat_i[8];
          end
        end
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = wb.wbs_dat_i[7:0];
          copi_d    = wb.wbs_dat_i[7];
          bit_cnt_d = 3'd0;
          cnt_d     = div_q;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], cipo_i};
          cnt_d   = div_q;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == 8'd0) begin
          sck_d = 1'b0;
          cnt_d = div_q;
          if (bit_cnt_q == 3'd7) begin
            // Completion outranks a same-cycle RXDATA read clearing rx_valid.
            rxdata_d   = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            copi_d    = shift_q[7];
            state_d   = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sck_q       <= 1'b0;
      copi_q      <= 1'b0;
      rxdata_q    <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      div_q       <= DIV_RESET;
      cs_assert_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sck_q       <= sck_d;
      copi_q      <= copi_d;
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      div_q       <= div_d;
      cs_assert_q <= cs_assert_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Directed bench for wb_spi_bridge: register access, SPI mode-0 framing, overrun,
// divider extremes, mid-transfer reset and address decode.
module tb_wb_spi_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_spi_bridge_if bus ();
  logic sck, cs, copi, cipo;

  wb_spi_bridge #(.BASE_ADDR(BASE), .DIV_RESET(8'd3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .sck_o    (sck),
    .cs_o     (cs),
    .copi_o   (copi),
    .cipo_i   (cipo)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI line monitor; counters only ever grow, the main thread keeps its own bases.
  int         mon_rises   = 0;
  int         mon_falls   = 0;
  int         mon_toggles = 0;
  int         mon_busy    = 0;
  logic [7:0] mon_copi    = 8'h00;
  logic       prev_sck    = 1'b0;

  always @(posedge clk) begin
    #1;
    if (dut.busy) mon_busy++;
    if (sck !== prev_sck) mon_toggles++;
    if (sck && !prev_sck) begin
      mon_rises++;
      mon_copi = {mon_copi[6:0], copi};
    end
    if (!sck && prev_sck) mon_falls++;
    prev_sck = sck;
  end

  // Rapcore reply model: bit k of the pattern (MSB first) is presented after k falls.
  logic [7:0] cipo_pat   = 8'h00;
  int         base_falls = 0;
  int         base_rises = 0;
  int         base_tog   = 0;
  int         base_busy  = 0;

  function automatic logic cipo_bit(input logic [7:0] pat, input int k);
    if (k < 0 || k > 7) return 1'b0;
    return pat[7-k];
  endfunction

  assign cipo = cipo_bit(cipo_pat, mon_falls - base_falls);

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rd    = bus.wbs_dat_o;
      end
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    logic [31:0] d;
    logic        a;
    wb_xfer(1'b1, adr, dat, sel, d, a);
    check({tag, " ack"}, {31'd0, a}, 32'd1);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, d, a);
    check({tag, " ack"}, {31'd0, a}, 32'd1);
    check(tag, d, exp);
  endtask

  task automatic start_tx(input string tag, input logic [7:0] tx, input logic [7:0] pat);
    cipo_pat   = pat;
    base_falls = mon_falls;
    base_rises = mon_rises;
    base_tog   = mon_toggles;
    base_busy  = mon_busy;
    wb_wr(tag, A_TX, {24'd0, tx}, 4'h1);
  endtask

  // Leaves the caller #3 after the edge where busy was first seen low.
  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && dut.busy; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, " idle"}, {31'd0, dut.busy}, 32'd0);
    #2;
  endtask

  initial begin
    int acks;
    int consec;
    logic prev_ack;
    logic [31:0] d;
    logic        a;

    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst sck", {31'd0, sck}, 32'd0);
    check("rst cs", {31'd0, cs}, 32'd1);
    check("rst copi", {31'd0, copi}, 32'd0);
    check("rst ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst dat", bus.wbs_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wb_rd_chk("status0", A_ST, 32'h0);
    wb_rd_chk("ctrl0", A_CT, 32'h003);
    check("idle sck", {31'd0, sck}, 32'd0);
    check("idle cs", {31'd0, cs}, 32'd1);

    // H=4 byte with chip select asserted through the upper CTRL lane only.
    wb_wr("ctrl cs", A_CT, 32'h100, 4'h2);
    check("cs asserted", {31'd0, cs}, 32'd0);
    wb_rd_chk("ctrl cs rd", A_CT, 32'h103);
    start_tx("tx a5", 8'hA5, 8'h3C);
    wait_idle("a5", 400);
    check("a5 busy cycles", mon_busy - base_busy, 32'd64);
    check("a5 sck pulses", mon_rises - base_rises, 32'd8);
    check("a5 copi bits", {24'd0, mon_copi}, 32'hA5);
    wb_rd_chk("a5 status", A_ST, 32'h2);
    wb_rd_chk("a5 rxdata", A_RX, 32'h3C);
    wb_rd_chk("a5 status clr", A_ST, 32'h0);

    // Overrun and frozen CTRL during a byte.
    start_tx("tx 5a", 8'h5A, 8'h81);
    wb_wr("tx overrun", A_TX, 32'h11, 4'h1);
    wb_wr("ctrl busy", A_CT, 32'h000, 4'h3);
    wb_rd_chk("ovr status busy", A_ST, 32'h5);
    wb_rd_chk("ctrl unchanged", A_CT, 32'h103);
    wait_idle("5a", 400);
    check("5a copi bits", {24'd0, mon_copi}, 32'h5A);
    check("5a busy cycles", mon_busy - base_busy, 32'd64);
    wb_rd_chk("5a status", A_ST, 32'h6);
    wb_wr("ovr clear", A_ST, 32'h4, 4'h1);
    wb_rd_chk("ovr cleared", A_ST, 32'h2);
    wb_rd_chk("5a rxdata", A_RX, 32'h81);
    wb_rd_chk("5a status clr", A_ST, 32'h0);

    // div=0: one wb_clk per half period.
    wb_wr("ctrl div0", A_CT, 32'h0, 4'h1);
    wb_rd_chk("ctrl div0 rd", A_CT, 32'h100);
    start_tx("tx ff", 8'hFF, 8'h00);
    wait_idle("ff", 100);
    check("ff busy cycles", mon_busy - base_busy, 32'd16);
    check("ff sck toggles", mon_toggles - base_tog, 32'd16);
    check("ff sck pulses", mon_rises - base_rises, 32'd8);
    check("ff copi bits", {24'd0, mon_copi}, 32'hFF);
    // Issued on the cycle right after busy fell.
    start_tx("tx 3c", 8'h3C, 8'h4D);
    wb_rd_chk("3c status busy", A_ST, 32'h3);
    wait_idle("3c", 100);
    check("3c busy cycles", mon_busy - base_busy, 32'd16);
    check("3c copi bits", {24'd0, mon_copi}, 32'h3C);
    wb_rd_chk("3c status", A_ST, 32'h2);

    // Reset 20 cycles into an H=4 byte, with rx_valid still pending.
    wb_wr("ctrl div3", A_CT, 32'h3, 4'h1);
    start_tx("tx 96", 8'h96, 8'hFF);
    repeat (20) @(posedge clk);
    #1;
    check("pre-rst sck", {31'd0, sck}, 32'd1);
    check("pre-rst cs", {31'd0, cs}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort sck", {31'd0, sck}, 32'd0);
    check("abort cs", {31'd0, cs}, 32'd1);
    check("abort busy", {31'd0, dut.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd_chk("abort status", A_ST, 32'h0);
    wb_rd_chk("abort rxdata", A_RX, 32'h0);
    wb_rd_chk("abort ctrl", A_CT, 32'h003);

    // Decode: out-of-window address gets no ack.
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, d, a);
    check("miss ack", {31'd0, a}, 32'd0);

    // Held strobe on a valid address: acks on alternate cycles only.
    @(negedge clk);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = A_CT;
    bus.wbs_sel_i = 4'hF;
    acks     = 0;
    consec   = 0;
    prev_ack = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) acks++;
      if (bus.wbs_ack_o && prev_ack) consec++;
      prev_ack = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    check("held acks", acks, 32'd3);
    check("held back-to-back", consec, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("quiet ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("quiet dat", bus.wbs_dat_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
